// File: rtl/control_unit_pkg.sv
// Shared CPU definitions: opcodes, instruction classes, control states and the
// strobe bundle driven by the control unit.
package control_unit_pkg;

  localparam logic [4:0] OP_LD   = 5'b00000;
  localparam logic [4:0] OP_ST   = 5'b00010;
  localparam logic [4:0] OP_ADD  = 5'b00011;
  localparam logic [4:0] OP_SUB  = 5'b00100;
  localparam logic [4:0] OP_AND  = 5'b00101;
  localparam logic [4:0] OP_OR   = 5'b00110;
  localparam logic [4:0] OP_SHR  = 5'b00111;
  localparam logic [4:0] OP_SHL  = 5'b01000;
  localparam logic [4:0] OP_ADDI = 5'b01100;
  localparam logic [4:0] OP_ANDI = 5'b01101;
  localparam logic [4:0] OP_ORI  = 5'b01110;
  localparam logic [4:0] OP_MUL  = 5'b01111;
  localparam logic [4:0] OP_DIV  = 5'b10000;
  localparam logic [4:0] OP_HALT = 5'b11011;

  typedef enum logic [2:0] {
    CLS_NOP, CLS_RTYPE, CLS_ITYPE, CLS_LD, CLS_ST, CLS_MULDIV, CLS_HALT
  } instr_class_e;

  typedef enum logic [3:0] {
    S_T0, S_T1, S_T1_WAIT, S_T2, S_T3, S_T4, S_T5, S_T6, S_T7, S_HALTED
  } state_e;

  typedef struct packed {
    logic pc_out, mar_in, z_in, inc_pc, pc_in, read, mdr_in, mdr_out, ir_in;
    logic gra, grb, grc, rin, rout, ba_out, y_in, c_out;
    logic zlow_out, zhigh_out, hi_in, lo_in, write;
  } strobes_t;

endpackage

// File: rtl/control_unit_op_decode.sv
// Combinational opcode decode: instruction class plus the ALU operation used in T4.
module op_decode
  import control_unit_pkg::*;
(
  input  logic [4:0]   opcode,
  output instr_class_e cls,
  output logic [4:0]   alu_op
);

  always_comb begin
    // NOTE: every output gets a default first so no path through the case infers a latch.
    cls    = CLS_NOP;
    alu_op = OP_ADD;
    case (opcode)
      OP_ADD, OP_SUB, OP_AND, OP_OR, OP_SHR, OP_SHL: begin
        cls    = CLS_RTYPE;
        alu_op = opcode;
      end
      OP_ADDI: cls = CLS_ITYPE;
      OP_ANDI: begin
        cls    = CLS_ITYPE;
        alu_op = OP_AND;
      end
      OP_ORI: begin
        cls    = CLS_ITYPE;
        alu_op = OP_OR;
      end
      OP_LD:   cls = CLS_LD;
      OP_ST:   cls = CLS_ST;
      OP_MUL, OP_DIV: begin
        cls    = CLS_MULDIV;
        alu_op = opcode;
      end
      OP_HALT: cls = CLS_HALT;
      default: ;
    endcase
  end

endmodule

// File: rtl/control_unit.sv
// Moore control sequencer: fetch T0-T2, decode in T3, class-specific execute
// steps with memory wait states, and a HALTED state left only through clr.
module control_unit
  import control_unit_pkg::*;
(
  input  logic        clk,
  input  logic        clr,
  input  logic [31:0] IR_Data,
  input  logic        mem_rdy,
  output logic        PC_out, MAR_in, Z_in, IncPC, PC_in, Read, MDR_in, MDR_out, IR_in,
  output logic        Gra, Grb, Grc, Rin, Rout, BAout, Y_in, C_out,
  output logic        Zlow_out, Zhigh_out, HI_in, LO_in, Write,
  output logic [4:0]  alu_instruction,
  output logic        run
);

  state_e       state_q, state_d;
  instr_class_e cls;
  logic [4:0]   alu_op;
  strobes_t     strobes;
  logic [4:0]   alu_sel;
  logic         run_sel;
  logic         unused_ir_bits;

  assign unused_ir_bits = ^IR_Data[26:0];

  op_decode u_op_decode (
    .opcode (IR_Data[31:27]),
    .cls    (cls),
    .alu_op (alu_op)
  );

  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    if (clr) state_q <= S_T0;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_T0:              state_d = S_T1;
      S_T1, S_T1_WAIT:   state_d = mem_rdy ? S_T2 : S_T1_WAIT;
      S_T2:              state_d = S_T3;
      S_T3: case (cls)
        CLS_NOP:  state_d = S_T0;
        CLS_HALT: state_d = S_HALTED;
        default:  state_d = S_T4;
      endcase
      S_T4:              state_d = S_T5;
      S_T5:              state_d = (cls == CLS_RTYPE || cls == CLS_ITYPE) ? S_T0 : S_T6;
      S_T6: case (cls)
        CLS_LD:  state_d = mem_rdy ? S_T7 : S_T6;
        CLS_ST:  state_d = S_T7;
        default: state_d = S_T0;
      endcase
      S_T7:              state_d = (cls == CLS_ST && !mem_rdy) ? S_T7 : S_T0;
      S_HALTED:          state_d = S_HALTED;
      default:           state_d = S_T0;
    endcase
  end

  // T1 only strobes PC_in on its first cycle; the wait copy keeps just the read path.
  always_comb begin
    strobes = '0;
    alu_sel = OP_ADD;
    run_sel = 1'b1;
    case (state_q)
      S_T0: begin
        strobes.pc_out = 1'b1; strobes.mar_in = 1'b1;
        strobes.inc_pc = 1'b1; strobes.z_in   = 1'b1;
      end
      S_T1: begin
        strobes.zlow_out = 1'b1; strobes.pc_in  = 1'b1;
        strobes.read     = 1'b1; strobes.mdr_in = 1'b1;
      end
      S_T1_WAIT: begin
        strobes.read = 1'b1; strobes.mdr_in = 1'b1;
      end
      S_T2: begin
        strobes.mdr_out = 1'b1; strobes.ir_in = 1'b1;
      end
      S_T3: case (cls)
        CLS_RTYPE, CLS_ITYPE: begin
          strobes.grb = 1'b1; strobes.rout = 1'b1; strobes.y_in = 1'b1;
        end
        CLS_LD, CLS_ST: begin
          strobes.grb    = 1'b1; strobes.rout = 1'b1;
          strobes.ba_out = 1'b1; strobes.y_in = 1'b1;
        end
        CLS_MULDIV: begin
          strobes.gra = 1'b1; strobes.rout = 1'b1; strobes.y_in = 1'b1;
        end
        default: ;
      endcase
      S_T4: begin
        alu_sel = alu_op;
        case (cls)
          CLS_RTYPE: begin
            strobes.grc = 1'b1; strobes.rout = 1'b1; strobes.z_in = 1'b1;
          end
          CLS_MULDIV: begin
            strobes.grb = 1'b1; strobes.rout = 1'b1; strobes.z_in = 1'b1;
          end
          default: begin
            strobes.c_out = 1'b1; strobes.z_in = 1'b1;
          end
        endcase
      end
      S_T5: begin
        strobes.zlow_out = 1'b1;
        case (cls)
          CLS_RTYPE, CLS_ITYPE: begin
            strobes.gra = 1'b1; strobes.rin = 1'b1;
          end
          CLS_MULDIV: strobes.lo_in  = 1'b1;
          default:    strobes.mar_in = 1'b1;
        endcase
      end
      S_T6: case (cls)
        CLS_LD: begin
          strobes.read = 1'b1; strobes.mdr_in = 1'b1;
        end
        CLS_ST: begin
          strobes.gra = 1'b1; strobes.rout = 1'b1; strobes.mdr_in = 1'b1;
        end
        default: begin
          strobes.zhigh_out = 1'b1; strobes.hi_in = 1'b1;
        end
      endcase
      S_T7: case (cls)
        CLS_LD: begin
          strobes.mdr_out = 1'b1; strobes.gra = 1'b1; strobes.rin = 1'b1;
        end
        default: strobes.write = 1'b1;
      endcase
      S_HALTED: run_sel = 1'b0;
      default: ;
    endcase
    // clr overrides everything, which also abandons any pending Read/Write.
    if (clr) begin
      strobes = '0;
      alu_sel = OP_ADD;
      run_sel = 1'b1;
    end
  end

  assign PC_out    = strobes.pc_out;
  assign MAR_in    = strobes.mar_in;
  assign Z_in      = strobes.z_in;
  assign IncPC     = strobes.inc_pc;
  assign PC_in     = strobes.pc_in;
  assign Read      = strobes.read;
  assign MDR_in    = strobes.mdr_in;
  assign MDR_out   = strobes.mdr_out;
  assign IR_in     = strobes.ir_in;
  assign Gra       = strobes.gra;
  assign Grb       = strobes.grb;
  assign Grc       = strobes.grc;
  assign Rin       = strobes.rin;
  assign Rout      = strobes.rout;
  assign BAout     = strobes.ba_out;
  assign Y_in      = strobes.y_in;
  assign C_out     = strobes.c_out;
  assign Zlow_out  = strobes.zlow_out;
  assign Zhigh_out = strobes.zhigh_out;
  assign HI_in     = strobes.hi_in;
  assign LO_in     = strobes.lo_in;
  assign Write     = strobes.write;
  assign alu_instruction = alu_sel;
  assign run       = run_sel;

endmodule
